mmio_uart_tx: RTL and testbench

Memory-mapped byte-output peripheral on the RV32 core's data bus. It accepts CPU byte writes into a small FIFO and serialises them as 8N1 UART frames on `tx`. On every byte launch it emits the `out_byte` / `out_byte_en` strobe pair, which the on-chip logic-analyzer probes alongside `mem_addr` and `m_read_en`. It sits directly upstream of the debug tap and of the board UART pin.

---
 rtl/mmio_uart_tx_if.sv | 25 ++
 rtl/mmio_uart_tx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if
//   Data-bus bundle between the RV32 core (master) and the memory-mapped
//   UART transmitter (slave).
//   mem_addr   : bus byte address
//   mem_wdata  : write data, only [7:0] is consumed by the UART
//   m_write_en : one-cycle write strobe
//   m_read_en  : one-cycle read strobe
//   mem_rdata  : registered read data returned by the slave
interface mmio_uart_tx_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        m_write_en;
  logic        m_read_en;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, m_write_en, m_read_en,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, m_write_en, m_read_en,
    output mem_rdata
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped byte-output peripheral. CPU writes to ADDR_DATA are queued
//   in a DEPTH-entry FIFO and serialised as 8N1 frames on tx (CLK_DIV clocks
//   per bit). ADDR_STAT reads return {27'b0, ovf, full, empty, busy,
//   frame_active} and clear the sticky overflow flag.
//
// Ports
//   clk         : single clock
//   rst         : asynchronous active-high reset
//   bus         : mmio_uart_tx_if.slave (address, write data, strobes, rdata)
//   out_byte    : byte being launched, held until the next launch
//   out_byte_en : one-cycle launch strobe
//   tx          : UART serial output, idle high
//   busy        : FIFO non-empty or frame in progress
//
// Configuration
//   OUT_BYTE_TAP_EN : when defined, out_byte/out_byte_en drive the
//                     logic-analyzer tap; when undefined both are tied low.
module mmio_uart_tx #(
  parameter logic [31:0] ADDR_DATA = 32'h8000_0000,
  parameter logic [31:0] ADDR_STAT = 32'h8000_0004,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CLK_DIV   = 234
) (
  input  logic               clk,
  input  logic               rst,
  mmio_uart_tx_if.slave      bus,
  output logic [7:0]         out_byte,
  output logic               out_byte_en,
  output logic               tx,
  output logic               busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(CLK_DIV);

  localparam logic [PW:0]   CNT_ZERO  = (PW+1)'(0);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL  = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [7:0]      mem_q [DEPTH];

  logic            wr_hit_s;
  logic            stat_hit_s;
  logic            pop_s;
  logic            push_s;
  logic            ovf_evt_s;
  logic            baud_done_s;
  logic            frame_active_s;
  logic            full_s;
  logic            empty_s;
  logic [31:0]     status_s;
  logic            unused_wdata_s;

  assign unused_wdata_s = ^bus.mem_wdata[31:8];

  assign wr_hit_s       = bus.m_write_en && (bus.mem_addr == ADDR_DATA);
  assign stat_hit_s     = bus.m_read_en && (bus.mem_addr == ADDR_STAT);
  assign full_s         = (count_q == CNT_FULL);
  assign empty_s        = (count_q == CNT_ZERO);
  assign frame_active_s = (state_q != S_IDLE);
  assign pop_s          = (state_q == S_IDLE) && !empty_s;
  // A full FIFO still accepts the write when the head leaves in the same cycle.
  assign push_s         = wr_hit_s && (!full_s || pop_s);
  assign ovf_evt_s      = wr_hit_s && !push_s;
  assign baud_done_s    = (baud_q == BAUD_LAST);
  assign status_s       = {27'd0, ovf_q, full_s, empty_s, busy_q, frame_active_s};

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM next-state, baud counter and shift register
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = BAUD_ZERO;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_done_s) begin
          baud_d  = BAUD_ZERO;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_done_s) begin
          baud_d  = BAUD_ZERO;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_done_s) begin
          baud_d  = BAUD_ZERO;
          state_d = S_IDLE;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      default: begin
        baud_d  = BAUD_ZERO;
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered line level follows the state being entered, so tx changes
  // on the same edge as the state register.
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != CNT_ZERO);
  end

  // Bus read data and sticky overflow next-state
  always_comb begin
    rdata_d = rdata_q;
    ovf_d   = ovf_q;
    if (bus.m_read_en) begin
      rdata_d = stat_hit_s ? status_s : 32'd0;
    end else begin
      rdata_d = rdata_q;
    end
    // An overflow in the clearing cycle wins over the clear.
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (stat_hit_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= BAUD_ZERO;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= 32'd0;
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= CNT_ZERO;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.mem_wdata[7:0];
    end
  end

`ifdef OUT_BYTE_TAP_EN
  logic       launch_d;
  logic [7:0] head_s;
  logic       out_byte_en_q;
  logic [7:0] out_byte_q;

  // The strobe is registered one cycle early: it is raised for the IDLE
  // cycle in which the head will be popped. When the FIFO is empty the
  // head can only be the byte being written right now.
  assign launch_d = (state_d == S_IDLE) && (count_d != CNT_ZERO);
  assign head_s   = empty_s ? bus.mem_wdata[7:0] : mem_q[rd_ptr_q];

  // Launch tap registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_byte_en_q <= 1'b0;
      out_byte_q    <= 8'd0;
    end else begin
      out_byte_en_q <= launch_d;
      if (launch_d) begin
        out_byte_q <= head_s;
      end
    end
  end

  assign out_byte_en = out_byte_en_q;
  assign out_byte    = out_byte_q;
`else
  assign out_byte_en = 1'b0;
  assign out_byte    = 8'd0;
`endif

  assign tx            = tx_q;
  assign busy          = busy_q;
  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx (DEPTH = 4, CLK_DIV = 4). A timeline
//   model derives every cycle's tx / busy / tap / rdata from the byte queue
//   and the launch time of the current frame; directed sequences add
//   hand-computed literal expectations.
module tb_mmio_uart_tx;
  localparam int          DIV    = 4;
  localparam int          DEP    = 4;
  localparam logic [31:0] A_DATA = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
`ifdef OUT_BYTE_TAP_EN
  localparam bit TAP = 1'b1;
`else
  localparam bit TAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] out_byte;
  logic       out_byte_en;
  logic       tx;
  logic       busy;

  mmio_uart_tx_if bus_if();

  mmio_uart_tx #(
    .ADDR_DATA (A_DATA),
    .ADDR_STAT (A_STAT),
    .DEPTH     (DEP),
    .CLK_DIV   (DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .out_byte    (out_byte),
    .out_byte_en (out_byte_en),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int          m_cyc = 0;
  int          m_last = -100000;
  logic [7:0]  m_q[$];
  logic [7:0]  m_cur = 8'h00;
  logic        m_ovf = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_launch, m_fa, m_etx, m_ebusy, m_ovfe;
  int          m_off, m_lvl;
  logic [31:0] m_stat;
  int          pulses = 0;
  int          pulse_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_q.delete();
        m_last  = -100000;
        m_cur   = 8'h00;
        m_ovf   = 1'b0;
        m_rdata = 32'h0;
      end else begin
        // A byte launches in any cycle after the line has been idle for a
        // full frame, provided something is queued.
        m_launch = (m_q.size() != 0) && (m_cyc - m_last > 10 * DIV);
        if (m_launch) begin
          m_last = m_cyc;
          m_cur  = m_q[0];
        end
        m_off = m_cyc - m_last;
        m_fa  = (m_off >= 1) && (m_off <= 10 * DIV);
        if (!m_fa) begin
          m_etx = 1'b1;
        end else begin
          m_lvl = (m_off - 1) / DIV;
          if (m_lvl == 0)      m_etx = 1'b0;
          else if (m_lvl == 9) m_etx = 1'b1;
          else                 m_etx = m_cur[m_lvl-1];
        end
        m_ebusy = m_fa || (m_q.size() != 0);

        check("tx", tx, m_etx);
        check("busy", busy, m_ebusy);
        check("out_byte_en", out_byte_en, TAP & m_launch);
        check("out_byte", out_byte, TAP ? m_cur : 8'h00);
        check("mem_rdata", bus_if.mem_rdata, m_rdata);
        if (out_byte_en) begin
          pulses++;
          pulse_cyc.push_back(m_cyc);
        end

        // Inputs seen here are the ones sampled at the coming edge.
        m_stat = {27'd0, m_ovf, (m_q.size() == DEP), (m_q.size() == 0), m_ebusy, m_fa};
        if (m_launch) void'(m_q.pop_front());
        m_ovfe = 1'b0;
        if (bus_if.m_write_en && bus_if.mem_addr == A_DATA) begin
          if (m_q.size() < DEP) m_q.push_back(bus_if.mem_wdata[7:0]);
          else                  m_ovfe = 1'b1;
        end
        if (bus_if.m_read_en) m_rdata = (bus_if.mem_addr == A_STAT) ? m_stat : 32'h0;
        if (bus_if.m_read_en && bus_if.mem_addr == A_STAT) m_ovf = 1'b0;
        if (m_ovfe) m_ovf = 1'b1;
      end
      m_cyc++;
    end
  end

  // ---------------- driver helpers ----------------
  logic [7:0] wq[$];

  // Writes every byte of wq on consecutive cycles.
  task automatic wr_burst();
    @(posedge clk); #1;
    foreach (wq[i]) begin
      bus_if.mem_addr   = A_DATA;
      bus_if.mem_wdata  = {24'h00_0000, wq[i]};
      bus_if.m_write_en = 1'b1;
      @(posedge clk); #1;
    end
    bus_if.m_write_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    bus_if.mem_addr  = addr;
    bus_if.m_read_en = 1'b1;
    @(posedge clk); #1;
    bus_if.m_read_en = 1'b0;
    @(negedge clk);
    data = bus_if.mem_rdata;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, (n >= lim), 1'b0);
  endtask

  logic [31:0] rdv;
  logic [39:0] s40;
  logic [81:0] s82;
  logic [7:0]  dec1, dec2;
  logic        bz;
  int          p0, n, found;

  initial begin
    bus_if.mem_addr   = 32'h0;
    bus_if.mem_wdata  = 32'h0;
    bus_if.m_write_en = 1'b0;
    bus_if.m_read_en  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_obe", out_byte_en, 1'b0);
    check("rst_ob", out_byte, 8'h00);
    check("rst_rdata", bus_if.mem_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 100 quiet cycles, then status reads back only the empty flag (bit 2)
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) n++;
    end
    check("quiet100", n, 0);
    rd(A_STAT, rdv);
    check("stat_idle", rdv, 32'h0000_0004);
    rd(32'h8000_0008, rdv);
    check("rd_other", rdv, 32'h0);

    // Single byte 0x55: start, 01010101 LSB first, stop; 4 cycles per level
    p0 = pulses;
    wq = {8'h55};
    wr_burst();
    @(negedge clk);
    check("x55_obe", out_byte_en, TAP);
    check("x55_ob", out_byte, TAP ? 8'h55 : 8'h00);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s40[i] = tx;
      if (i == 39) bz = busy;
    end
    check("x55_wave", s40, 40'hF0F0F0F0F0);
    check("x55_busy_last", bz, 1'b1);
    @(negedge clk);
    check("x55_busy_fall", busy, 1'b0);
    check("x55_pulses", pulses - p0, TAP ? 1 : 0);

    // Two bytes back to back: A3 then 0F, one idle cycle between frames
    wq = {8'hA3, 8'h0F};
    wr_burst();
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1;
    end
    check("a3_start_seen", found, 1);
    s82[0] = tx;
    for (int i = 1; i < 82; i++) begin
      @(negedge clk);
      s82[i] = tx;
    end
    for (int k = 0; k < 8; k++) begin
      dec1[k] = s82[4*(k+1)+2];
      dec2[k] = s82[41+4*(k+1)+2];
    end
    check("dec_a3", dec1, 8'hA3);
    check("dec_0f", dec2, 8'h0F);
    check("gap_bits", {s82[41], s82[40], s82[39]}, 3'b011);
`ifdef OUT_BYTE_TAP_EN
    check("pulse_gap", pulse_cyc[$] - pulse_cyc[$-1], 41);
`else
    check("no_tap_pulses", pulses, 0);
`endif
    wait_idle("idle_after_a3", 200);

    // Overflow: DEPTH 4, six writes, byte 6 dropped
    p0 = pulses;
    wq = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    wr_burst();
    rd(A_STAT, rdv);
    check("ovf_stat1", rdv, 32'h0000_001B);
    rd(A_STAT, rdv);
    check("ovf_stat2", rdv, 32'h0000_000B);
    wait_idle("idle_after_ovf", 400);
    check("ovf_pulses", pulses - p0, TAP ? 5 : 0);

    // Reset during data bit 3 (a zero bit of F0); queued 0x11 is discarded
    wq = {8'hF0, 8'h11};
    wr_burst();
    repeat (17) @(negedge clk);
    check("pre_rst_tx", tx, 1'b0);
    #1 rst = 1'b1;
    #1 check("rst_async_tx", tx, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    p0 = pulses;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) n++;
    end
    check("post_rst_quiet", n, 0);
    check("post_rst_pulses", pulses - p0, 0);
    rd(A_STAT, rdv);
    check("post_rst_stat", rdv, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
